inv_shift_rows_stage: RTL

- Inverse-cipher ShiftRows stage of the AES datapath, sitting between InvSubBytes/AddRoundKey in the decrypt round.
- Accepts the state one row per beat as 32-bit words over a valid/ready interface.
- Assembles four rows, applies the inverse row rotation, and presents the 128-bit result on a registered valid/ready output.
- Assembly of the next block overlaps with holding of the current result.

---
 rtl/inv_shift_rows_stage.sv | 112 +++++++++++
 1 files changed

// File: rtl/inv_shift_rows_stage.sv
// AES decrypt-round ShiftRows stage: collects four 32-bit rows, rotates them, holds a 128-bit result.
// Optional macro INV_SHIFT_ROWS_FWD_EN adds a fwd_mode port selecting the forward rotation.

module inv_shift_rows_row #(
    parameter int ROW = 0
) (
    input  logic        fwd,
    input  logic [31:0] word,
    output logic [31:0] rot
);
    // Inverse rotates row r right by 8r bits; forward is the same amount to the left.
    localparam int RS = 8 * ROW;
    localparam int LS = (32 - 8 * ROW) % 32;

    function automatic logic [31:0] rotr(input logic [31:0] w, input int s);
        return (w >> s) | (w << (32 - s));
    endfunction

    assign rot = fwd ? rotr(word, LS) : rotr(word, RS);
endmodule

module inv_shift_rows_stage #(
    parameter int W_DATA = 128,
    parameter int W_CNT  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
`ifdef INV_SHIFT_ROWS_FWD_EN
    input  logic              fwd_mode,
`endif
    output logic              in_ready,
    input  logic [31:0]       in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_DATA-1:0] data_out,
    output logic [W_CNT-1:0]  blk_cnt,
    output logic              busy
);
    if (W_DATA != 128) begin : g_bad_width
        $error("inv_shift_rows_stage supports only W_DATA = 128");
    end

    logic [1:0]        cnt;
    logic [31:0]       asm_q [3];
    logic [3:0][31:0]  row_in;
    logic [3:0][31:0]  row_rot;
    logic              fwd;
    logic              accept;
    logic              last;
    logic              handoff;

`ifdef INV_SHIFT_ROWS_FWD_EN
    assign fwd = fwd_mode;
`else
    assign fwd = 1'b0;
`endif

    // Only the closing beat can stall: beats 0-2 land in the assembly slots while a result waits.
    assign in_ready = !(cnt == 2'd3 && out_valid && !out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign last     = accept && cnt == 2'd3;
    assign handoff  = out_valid && out_ready;
    assign busy     = (cnt != 2'd0) || out_valid;

    // Row 3 comes straight from the live beat so the block loads on the 4th accept.
    assign row_in = {in_word, asm_q[2], asm_q[1], asm_q[0]};

    for (genvar r = 0; r < 4; r++) begin : g_row
        inv_shift_rows_row #(.ROW(r)) u_row (
            .fwd  (fwd),
            .word (row_in[r]),
            .rot  (row_rot[r])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 2'd0;
            asm_q[0] <= '0;
            asm_q[1] <= '0;
            asm_q[2] <= '0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else if (accept) begin
            cnt <= cnt + 2'd1;
            case (cnt)
                2'd0:    asm_q[0] <= in_word;
                2'd1:    asm_q[1] <= in_word;
                2'd2:    asm_q[2] <= in_word;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            blk_cnt   <= '0;
        end else begin
            if (last) begin
                out_valid <= 1'b1;
                data_out  <= row_rot;
            end else if (handoff) begin
                out_valid <= 1'b0;
            end
            if (handoff) blk_cnt <= blk_cnt + W_CNT'(1);
        end
    end
endmodule
